// File: rtl/program_sequencer_if.sv
// Sequencer bus: program-load port, processor DIN/Run/Done handshake and status.
interface program_sequencer_if #(
  parameter int unsigned AW = 4
);
  logic          Start;
  logic          ProgWe;
  logic [AW-1:0] ProgAddr;
  logic [8:0]    ProgData;
  logic          Done;
  logic          Run;
  logic [8:0]    DOUT;
  logic [AW-1:0] Pc;
  logic          Busy;
  logic          Halted;
  logic          Error;

  modport master (
    input  Start, ProgWe, ProgAddr, ProgData, Done,
    output Run, DOUT, Pc, Busy, Halted, Error
  );

  modport slave (
    output Start, ProgWe, ProgAddr, ProgData, Done,
    input  Run, DOUT, Pc, Busy, Halted, Error
  );
endinterface

// File: rtl/program_sequencer.sv
// Instruction sequencer feeding the 9-bit processor's DIN/Run from a small program memory.
// Optional single-step mode: define SEQ_STEP_EN to add the Step input and PAUSE state.
module program_sequencer #(
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic Clk,
  input  logic Resetn,
`ifdef SEQ_STEP_EN
  input  logic Step,
`endif
  program_sequencer_if.master bus
);

  localparam int unsigned DEPTH    = 2**AW;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0]  OP_MOVI  = 3'b001;
  localparam logic [2:0]  OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HALT,
`ifdef SEQ_STEP_EN
    S_ERR,
    S_PAUSE
`else
    S_ERR
`endif
  } state_t;

  state_t        state, state_d;
  logic [8:0]    mem [DEPTH];
  logic          run_q, run_d;
  logic [8:0]    dout_q, dout_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          halted_q, halted_d;
  logic          error_q, error_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          imm_q, imm_d;
  logic [8:0]    word;
  logic          stopped;
  logic          done_ok;
  logic          expire;

  assign word    = mem[pc_q];
  assign stopped = (state == S_IDLE) || (state == S_HALT) || (state == S_ERR);
  // Done in the Run cycle (counter still 0) is not a completion.
  assign done_ok = bus.Done && (cnt_q != '0);
  assign expire  = (cnt_q == CNT_LAST) && !done_ok;

  always_ff @(posedge Clk) begin
    if (bus.ProgWe && stopped) mem[bus.ProgAddr] <= bus.ProgData;
  end

  always_comb begin
    state_d  = state;
    run_d    = 1'b0;
    dout_d   = dout_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    error_d  = error_q;
    cnt_d    = cnt_q;
    imm_d    = imm_q;
    case (state)
      S_IDLE, S_HALT, S_ERR: begin
        if (bus.Start) begin
          halted_d = 1'b0;
          error_d  = 1'b0;
          pc_d     = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (word[8:6] == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          dout_d  = word;
          run_d   = 1'b1;
          pc_d    = pc_q + 1'b1;
          cnt_d   = '0;
          imm_d   = (word[8:6] == OP_MOVI);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Immediate is presented from WAIT cycle 2; skipped if the watchdog fires first.
        if (imm_q && (cnt_q == 8'd1) && !expire) begin
          dout_d = word;
          pc_d   = pc_q + 1'b1;
        end
        if (done_ok) begin
`ifdef SEQ_STEP_EN
          state_d = S_PAUSE;
`else
          state_d = S_ISSUE;
`endif
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end
      end
`ifdef SEQ_STEP_EN
      S_PAUSE: begin
        if (Step) state_d = S_ISSUE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state    <= S_IDLE;
      run_q    <= 1'b0;
      dout_q   <= '0;
      pc_q     <= '0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
      imm_q    <= 1'b0;
    end else begin
      state    <= state_d;
      run_q    <= run_d;
      dout_q   <= dout_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
      imm_q    <= imm_d;
    end
  end

  assign bus.Run    = run_q;
  assign bus.DOUT   = dout_q;
  assign bus.Pc     = pc_q;
  assign bus.Busy   = !stopped;
  assign bus.Halted = halted_q;
  assign bus.Error  = error_q;

endmodule
